// File: rtl/matrix_pkg.sv
// Shared constants and types for the X-operand stream feeder.
//   DATA_W     : stream byte width
//   BLOCK_LEN  : bytes per block
//   NUM_BLOCKS : blocks held in the buffer
//   ADDR_W     : host byte address width (2^ADDR_W >= DEPTH)
package matrix_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BLOCK_LEN  = 32;
  localparam int unsigned NUM_BLOCKS = 5;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DEPTH      = BLOCK_LEN * NUM_BLOCKS;
  localparam int unsigned OFF_W      = $clog2(BLOCK_LEN);
  localparam int unsigned BLK_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/x_stream_feeder_if.sv
// Host-write and PADSTOP-stream signals of the X stream feeder.
//   master : host / PADSTOP side (drives start, writes, load requests)
//   slave  : feeder side (drives X_load, block_idx, status, wr_err)
interface x_stream_feeder_if;
  import matrix_pkg::*;

  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              input_load_en;
  logic              Xload_done;
  logic [DATA_W-1:0] X_load;
  logic [BLK_W-1:0]  block_idx;
  logic              busy;
  logic              feed_done;

  modport master (
    output start, wr_en, wr_addr, wr_data, input_load_en, Xload_done,
    input  wr_err, X_load, block_idx, busy, feed_done
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, input_load_en, Xload_done,
    output wr_err, X_load, block_idx, busy, feed_done
  );

endinterface

// File: rtl/x_feed_buf.sv
// Operand byte buffer: Depth x DataW register array, not reset.
//   clk_i   : clock
//   we_i    : synchronous write enable
//   waddr_i : write address (caller guarantees < Depth)
//   wdata_i : write data
//   raddr_i : combinational read address (caller guarantees < Depth)
//   rdata_o : read data
module x_feed_buf #(
  parameter int unsigned Depth = 160,
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/x_stream_feeder.sv
// Streams a host-loaded operand buffer to PADSTOP one byte per request, block by
// block; Xload_done rewinds to the start of the current block.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of x_stream_feeder_if (host writes, stream, status)
module x_stream_feeder
  import matrix_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  x_stream_feeder_if.slave bus
);

  localparam logic [OFF_W-1:0]  OffLast  = OFF_W'(BLOCK_LEN - 1);
  localparam logic [BLK_W-1:0]  BlkLast  = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W-1:0] BaseStep = ADDR_W'(BLOCK_LEN);
  // One extra bit so a depth of exactly 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

  feeder_state_t     state_q;
  logic [ADDR_W-1:0] base_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] x_load_q;
  logic [BLK_W-1:0]  block_idx_q;
  logic              wr_err_q;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_accept;

  assign rd_addr   = base_q + ADDR_W'(off_q);
  assign wr_accept = bus.wr_en && (state_q != STREAM) && ({1'b0, bus.wr_addr} < DepthLim);

  x_feed_buf #(
    .Depth (DEPTH),
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      off_q       <= '0;
      x_load_q    <= '0;
      block_idx_q <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_accept;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= STREAM;
            base_q      <= '0;
            off_q       <= '0;
            block_idx_q <= '0;
          end
        end
        STREAM: begin
          // Rewind wins over a same-cycle request; X_load and block hold.
          if (bus.Xload_done) begin
            off_q <= '0;
          end else if (bus.input_load_en) begin
            x_load_q <= rd_data;
            if (off_q != OffLast) begin
              off_q <= off_q + 1'b1;
            end else if (block_idx_q != BlkLast) begin
              off_q       <= '0;
              base_q      <= base_q + BaseStep;
              block_idx_q <= block_idx_q + 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            state_q     <= STREAM;
            base_q      <= '0;
            off_q       <= '0;
            block_idx_q <= '0;
          end else if (bus.input_load_en) begin
            x_load_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.X_load    = x_load_q;
  assign bus.block_idx = block_idx_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.busy      = (state_q == STREAM);
  assign bus.feed_done = (state_q == DONE);

endmodule

// File: tb/tb_x_stream_feeder.sv
module tb_x_stream_feeder;
  import matrix_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  x_stream_feeder_if bus ();

  x_stream_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int start;
    int ile;
    int xdone;
    int wr_en;
    int wr_addr;
    int wr_data;
    int exp_x;
    int exp_blk;
    int exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int x, input int blk, input int busy,
                            input int done, input int err);
    check({tag, " X_load"}, int'(bus.X_load), x);
    check({tag, " block_idx"}, int'(bus.block_idx), blk);
    check({tag, " busy"}, int'(bus.busy), busy);
    check({tag, " feed_done"}, int'(bus.feed_done), done);
    check({tag, " wr_err"}, int'(bus.wr_err), err);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start         = 1'b0;
    bus.wr_en         = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    bus.input_load_en = 1'b0;
    bus.Xload_done    = 1'b0;
  endtask

  // Block index right after absolute byte b has been loaded in a sequential stream.
  function automatic int blk_after(input int b);
    if (b == int'(DEPTH) - 1) return int'(NUM_BLOCKS) - 1;
    return (b + 1) / int'(BLOCK_LEN);
  endfunction

  // Request bytes first..last in order; buffer holds buf[i] = i.
  task automatic stream_bytes(input int first, input int last);
    for (int b = first; b <= last; b++) begin
      bus.input_load_en = 1'b1;
      tick();
      check_outs($sformatf("byte%0d", b), b, blk_after(b),
                 (b == int'(DEPTH) - 1) ? 0 : 1, (b == int'(DEPTH) - 1) ? 1 : 0, 0);
    end
    bus.input_load_en = 1'b0;
  endtask

  initial begin
    // Corner cases mid block 1, entered with X_load = 39, off = 8.
    //            start ile xdn wen addr data  x   blk err
    tbl[0]  = '{0,    1,  0,  0,  0,   0,    40, 1,  0};
    tbl[1]  = '{0,    0,  1,  0,  0,   0,    40, 1,  0};  // rewind, X_load holds
    tbl[2]  = '{0,    1,  0,  0,  0,   0,    32, 1,  0};
    tbl[3]  = '{0,    1,  0,  0,  0,   0,    33, 1,  0};
    tbl[4]  = '{0,    1,  1,  0,  0,   0,    33, 1,  0};  // rewind beats request
    tbl[5]  = '{0,    1,  0,  0,  0,   0,    32, 1,  0};
    tbl[6]  = '{0,    0,  0,  0,  0,   0,    32, 1,  0};
    tbl[7]  = '{0,    0,  0,  1,  5,   8'hAA, 32, 1,  1};  // write in STREAM rejected
    tbl[8]  = '{0,    0,  0,  0,  0,   0,    32, 1,  0};
    tbl[9]  = '{1,    0,  0,  0,  0,   0,    32, 1,  0};  // start ignored in STREAM
    tbl[10] = '{0,    1,  0,  0,  0,   0,    33, 1,  0};

    drive_idle();
    #2 rst_n = 1'b0;
    #1 check_outs("reset", 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(i);
      bus.wr_data = DATA_W'(i);
      tick();
    end
    check("load wr_err", int'(bus.wr_err), 0);

    bus.wr_addr = ADDR_W'(DEPTH);
    bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    check("oob wr_err", int'(bus.wr_err), 1);
    tick();
    check("oob wr_err pulse", int'(bus.wr_err), 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs("start", 0, 0, 1, 0, 0);

    stream_bytes(0, int'(DEPTH) - 1);
    bus.input_load_en = 1'b1;
    tick();
    bus.input_load_en = 1'b0;
    check_outs("drain", 0, int'(NUM_BLOCKS) - 1, 0, 1, 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs("restart", 0, 0, 1, 0, 0);
    stream_bytes(0, 39);

    for (int i = 0; i < 11; i++) begin
      bus.start         = (tbl[i].start != 0);
      bus.input_load_en = (tbl[i].ile != 0);
      bus.Xload_done    = (tbl[i].xdone != 0);
      bus.wr_en         = (tbl[i].wr_en != 0);
      bus.wr_addr       = ADDR_W'(tbl[i].wr_addr);
      bus.wr_data       = DATA_W'(tbl[i].wr_data);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].exp_x, tbl[i].exp_blk, 1, 0, tbl[i].exp_err);
    end
    drive_idle();

    stream_bytes(34, 70);

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1 check_outs("async reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    bus.input_load_en = 1'b1;
    tick();
    tick();
    bus.input_load_en = 1'b0;
    check_outs("no start after reset", 0, 0, 0, 0, 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs("start after reset", 0, 0, 1, 0, 0);
    stream_bytes(0, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/x_stream_feeder.md
Name: x_stream_feeder

Overview:
- Upstream stage of PADSTOP in the matrix peripheral.
- Holds a host-loaded byte buffer of operand data. Streams it to PADSTOP one byte per `input_load_en` cycle, block by block.
- When PADSTOP asserts `Xload_done`, the feeder rewinds and replays the current block.
- Replaces testbench-side pointer logic with synthesizable RTL.

Parameters:
- DATA_W, 8: width of each stream byte (matches X_load).
- BLOCK_LEN, 32: bytes per block.
- NUM_BLOCKS, 5: blocks held in the buffer. Depth = BLOCK_LEN*NUM_BLOCKS = 160.
- ADDR_W, 8: host write address width. Must satisfy 2^ADDR_W >= depth.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins streaming from block 0.
- wr_en  in  1  host write strobe.
- wr_addr  in  ADDR_W  host byte address.
- wr_data  in  DATA_W  host write data.
- wr_err  out  1  one-cycle pulse: write rejected.
- input_load_en  in  1  PADSTOP requests the next byte.
- Xload_done  in  1  PADSTOP signals end of current block consumption; rewind.
- X_load  out  DATA_W  registered byte to PADSTOP.
- block_idx  out  3  index of the block currently streaming.
- busy  out  1  high in STREAM.
- feed_done  out  1  high in DONE.

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - X_load = 0, block_idx = 0, busy = 0, feed_done = 0, wr_err = 0.
  - Internal base = 0, off = 0.
  - Buffer contents are not reset.
- States:
  - IDLE: start -> STREAM, with base = 0, off = 0, block_idx = 0.
  - STREAM: busy = 1. Priority per cycle:
    1. Xload_done = 1: off <= 0; X_load holds; block not advanced. This wins over input_load_en in the same cycle.
    2. Otherwise, input_load_en = 1: X_load <= buf[base+off]; one-cycle latency from request to valid byte.
       - If off < BLOCK_LEN-1: off <= off+1.
       - If off == BLOCK_LEN-1 and block_idx < NUM_BLOCKS-1: off <= 0, base <= base+BLOCK_LEN, block_idx <= block_idx+1.
       - If off == BLOCK_LEN-1 and block_idx == NUM_BLOCKS-1: go to DONE.
    3. Neither: all registers hold.
  - DONE: feed_done = 1; X_load <= 0 on the next input_load_en. start -> STREAM from block 0, same as from IDLE.
- start while in STREAM is ignored.
- Host writes:
  - Accepted only in IDLE or DONE, and only when wr_addr < depth: buf[wr_addr] <= wr_data on the same edge.
  - Rejected when wr_en is high in STREAM or wr_addr >= depth: write dropped, wr_err pulses for one cycle (registered).
- Buffer read is combinational from the register array; only X_load is registered.
- Reset asserted mid-stream returns immediately to reset values. A new start is then required.
- Arithmetic:
  - base+off is computed at ADDR_W width.
  - off is clog2(BLOCK_LEN) bits and wraps only under the explicit rules above, never by overflow.

Decomposition:
- Package matrix_pkg holds:
  - Constants DATA_W, BLOCK_LEN, NUM_BLOCKS, and derived DEPTH.
  - Enum feeder_state_t {IDLE, STREAM, DONE}.
- One sub-module, x_feed_buf: DEPTH x DATA_W register array with one synchronous write port and one combinational read port.
- The FSM and pointers stay in the top level.

Test Plan:
- Load buf[i] = i for i = 0..159; start; hold input_load_en = 1 for 160 cycles.
  -> X_load = 0,1,...,159, each one cycle after its request. block_idx steps 0→4 at X_load = 31, 63, 95, 127. feed_done rises after byte 159; the next request gives X_load = 0.
- Mid block 1: after byte 40 (off = 8), assert Xload_done for one cycle, then resume requests.
  -> X_load holds 40 during Xload_done. The next bytes are 32, 33, ... and block_idx stays 1.
- Xload_done and input_load_en high in the same cycle.
  -> X_load unchanged, off resets to 0, no advance.
- In STREAM, wr_en = 1, addr 5, data 0xAA.
  -> wr_err pulses for 1 cycle; buf[5] is still 5 on replay.
- In IDLE, write addr 160 (out of range).
  -> wr_err pulses; no buffer change.
- Deassert rst_n asynchronously at byte 70, release it, then start.
  -> Outputs are 0 immediately on reset. Streaming restarts at byte 0, block_idx = 0.
